sd_fifo_ctrl: RTL and testbench
===============================

// Module: sd_fifo_ctrl
// PURPOSE
//  Parametrised synchronous show-ahead FIFO for the SD data path, between the SD DAT engine and the bus/DMA side.
//  Extends the fixed 32x256 SD FIFO with configurable width and depth, almost-full/almost-empty thresholds and protected pointers.
//  Protected pointers: a push on full and a pop on empty are dropped and flagged.
//  Also adds error-clear and an optional high-water-mark monitor.
// PARAMETERS
//  DATA_WIDTH  32  word width in bits (>=1)
//  DEPTH_LOG2  8   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (>=2)
//  AF_MARGIN   4   o_fifo_almost_full asserts when items >= DEPTH-AF_MARGIN (0 < AF_MARGIN < DEPTH)
//  AE_MARGIN   4   o_fifo_almost_empty asserts when items <= AE_MARGIN (0 <= AE_MARGIN < DEPTH)
// PORTS
//  i_clk                 in   1              single clock, all logic rising-edge
//  i_reset               in   1              synchronous, active-high reset
//  i_fifo_flush          in   1              empty FIFO, clear flags
//  i_fifo_clear_errors   in   1              clear sticky overrun/underrun only
//  i_fifo_push           in   1              write i_fifo_data this cycle
//  i_fifo_data           in   DATA_WIDTH     write data
//  i_fifo_pop            in   1              consume head word
//  o_fifo_data           out  DATA_WIDTH     head word (show-ahead, valid when !o_fifo_empty)
//  o_fifo_empty          out  1              items == 0
//  o_fifo_full           out  1              items == DEPTH
//  o_fifo_almost_empty   out  1              items <= AE_MARGIN
//  o_fifo_almost_full    out  1              items >= DEPTH-AF_MARGIN
//  o_fifo_items          out  DEPTH_LOG2+1   current occupancy 0..DEPTH
//  o_fifo_overrun        out  1              sticky: push attempted while full and not popped
//  o_fifo_underrun       out  1              sticky: pop attempted while empty
//  o_fifo_peak           out  DEPTH_LOG2+1   max occupancy since flush (SD_FIFO_PEAK_EN only)
// BEHAVIOUR
//  - Reset: pointers 0, items 0, empty=1, almost_empty=1, full=0, almost_full=0, overrun=0, underrun=0, peak=0.
//    o_fifo_data is undefined at reset.
//  - Pointers are DEPTH_LOG2+1 bits with MSB wrap flag. Status flags and items derive from registered pointers, so there is no combinational path from push/pop.
//  - Write latency: a word pushed in cycle N is visible on o_fifo_data and counted in items at N+1.
//    o_fifo_data is an asynchronous read of the head entry.
//  - Push accepted iff !full || pop_accepted. A rejected push sets overrun; memory and pointers are untouched (no overwrite).
//  - Pop accepted iff !empty. A rejected pop sets underrun; rdptr is unchanged.
//  - Push+pop on full: both accepted, items unchanged, no overrun.
//  - Push+pop on empty: push accepted, pop rejected, underrun set, items becomes 1.
//  - Pointer wrap: at index DEPTH-1 the low bits return to 0 and the MSB toggles. Items = wrptr - rdptr, modulo 2**(DEPTH_LOG2+1).
//  - Flush has priority over push, pop and clear_errors in the same cycle.
//    It zeroes pointers, clears both sticky flags and peak; push/pop that cycle are discarded with no flags.
//  - clear_errors clears the sticky flags. A violation in the same cycle wins and leaves the flag set.
//  - Sticky flags persist until reset, flush or clear_errors.
//  - i_reset overrides everything. Reset mid-transfer loses all contents with no flag.
// CONFIGURATION
//  SD_FIFO_PEAK_EN defined:
//  - o_fifo_peak is a register updated to the next-state items when that exceeds the current peak.
//  - It is cleared by reset and flush only.
//  SD_FIFO_PEAK_EN undefined:
//  - o_fifo_peak is tied to 0 and no peak register exists.
//  - All other behaviour is identical.
// STRUCTURE
//  - Package sd_fifo_pkg: localparam helpers for items/pointer width (DEPTH_LOG2+1), threshold compare constants, and the flag bit-index constants used by the SD status register.
//  - Sub-module sd_fifo_ram: DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port, inferable as distributed RAM.
//  - Pointer, flag and peak logic live in sd_fifo_ctrl.
// TESTING (bench DATA_WIDTH=32, DEPTH_LOG2=4, AF_MARGIN=4, AE_MARGIN=2)
//  1. Reset, then push 0x1..0x10 one per cycle -> full=1 after the 16th push, almost_full from items=12, items=16; popping yields 0x1..0x10 in order, then empty=1.
//  2. At full, push 0xDEAD -> overrun=1, items=16, head unchanged (0x1); then pop+push 0xBEEF same cycle -> items=16, no new flag, 0xBEEF read last.
//  3. At empty, pop -> underrun=1, items=0; pop+push 0x55 same cycle -> items=1, head=0x55, underrun stays 1.
//  4. Run 40 push/pop pairs offset by 3 items to wrap pointers twice -> data order preserved, items=3 throughout, almost_empty=0.
//  5. Fill 9 items, set overrun, then flush+push+pop same cycle -> items=0, empty=1, overrun=0, peak=0 (PEAK_EN).
//  6. PEAK_EN: push 7, pop 5, push 2 -> peak=7, items=4; clear_errors leaves peak=7; without the macro, peak reads 0.

Source files
------------

// File: rtl/sd_fifo_pkg.sv
// rtl/sd_fifo_pkg.sv - shared widths, threshold helpers and status flag bit indices for the SD FIFO
package sd_fifo_pkg;

    localparam int FLAG_EMPTY        = 0;
    localparam int FLAG_FULL         = 1;
    localparam int FLAG_ALMOST_EMPTY = 2;
    localparam int FLAG_ALMOST_FULL  = 3;
    localparam int FLAG_OVERRUN      = 4;
    localparam int FLAG_UNDERRUN     = 5;
    localparam int FLAG_W            = 6;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic int af_level(input int depth_log2, input int af_margin);
        return (1 << depth_log2) - af_margin;
    endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// rtl/sd_fifo_ram.sv - FIFO storage, synchronous write and asynchronous read
module sd_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sd_fifo_ctrl.sv
// rtl/sd_fifo_ctrl.sv - show-ahead SD data FIFO with protected pointers and sticky errors
// Optional high-water-mark register enabled by SD_FIFO_PEAK_EN.
module sd_fifo_ctrl
    import sd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int AF_MARGIN  = 4,
    parameter int AE_MARGIN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fifo_flush,
    input  logic                  i_fifo_clear_errors,
    input  logic                  i_fifo_push,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_pop,
    output logic [DATA_WIDTH-1:0] o_fifo_data,
    output logic                  o_fifo_empty,
    output logic                  o_fifo_full,
    output logic                  o_fifo_almost_empty,
    output logic                  o_fifo_almost_full,
    output logic [DEPTH_LOG2:0]   o_fifo_items,
    output logic                  o_fifo_overrun,
    output logic                  o_fifo_underrun,
    output logic [DEPTH_LOG2:0]   o_fifo_peak
);

    localparam int            PW      = ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0] DEPTH_V = PW'(2 ** DEPTH_LOG2);
    localparam logic [PW-1:0] AF_V    = PW'(af_level(DEPTH_LOG2, AF_MARGIN));
    localparam logic [PW-1:0] AE_V    = PW'(AE_MARGIN);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, items;
    logic          ovr_q, ovr_d, udr_q, udr_d;
    logic          push_acc, pop_acc;

    assign items = wr_q - rd_q;

    always_comb begin
        pop_acc  = i_fifo_pop && (items != '0);
        push_acc = i_fifo_push && ((items != DEPTH_V) || pop_acc);
        wr_d     = wr_q;
        rd_d     = rd_q;
        ovr_d    = ovr_q;
        udr_d    = udr_q;
        if (i_fifo_flush) begin
            wr_d  = '0;
            rd_d  = '0;
            ovr_d = 1'b0;
            udr_d = 1'b0;
        end else begin
            if (push_acc) wr_d = wr_q + PW'(1);
            if (pop_acc)  rd_d = rd_q + PW'(1);
            // A violation in the same cycle as clear_errors keeps the flag set.
            if (i_fifo_push && !push_acc)   ovr_d = 1'b1;
            else if (i_fifo_clear_errors)   ovr_d = 1'b0;
            if (i_fifo_pop && !pop_acc)     udr_d = 1'b1;
            else if (i_fifo_clear_errors)   udr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovr_q <= ovr_d;
            udr_q <= udr_d;
        end
    end

    sd_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (push_acc && !i_fifo_flush),
        .i_waddr (wr_q[DEPTH_LOG2-1:0]),
        .i_wdata (i_fifo_data),
        .i_raddr (rd_q[DEPTH_LOG2-1:0]),
        .o_rdata (o_fifo_data)
    );

`ifdef SD_FIFO_PEAK_EN
    logic [PW-1:0] peak_q, peak_d, items_d;

    always_comb begin
        items_d = wr_d - rd_d;
        peak_d  = peak_q;
        if (i_fifo_flush)          peak_d = '0;
        else if (items_d > peak_q) peak_d = items_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign o_fifo_peak = peak_q;
`else
    assign o_fifo_peak = '0;
`endif

    assign o_fifo_empty        = (items == '0);
    assign o_fifo_full         = (items == DEPTH_V);
    assign o_fifo_almost_empty = (items <= AE_V);
    assign o_fifo_almost_full  = (items >= AF_V);
    assign o_fifo_items        = items;
    assign o_fifo_overrun      = ovr_q;
    assign o_fifo_underrun     = udr_q;

endmodule

// File: tb/tb_sd_fifo_ctrl.sv
// tb/tb_sd_fifo_ctrl.sv - scoreboard bench for sd_fifo_ctrl (16 x 32, AF_MARGIN 4, AE_MARGIN 2)
module tb_sd_fifo_ctrl;

    localparam int DW = 32;
    localparam int DL = 4;
    localparam int DEPTH = 16;
    localparam int AFM = 4;
    localparam int AEM = 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_fifo_flush = 1'b0;
    logic          i_fifo_clear_errors = 1'b0;
    logic          i_fifo_push = 1'b0;
    logic [DW-1:0] i_fifo_data = '0;
    logic          i_fifo_pop = 1'b0;
    logic [DW-1:0] o_fifo_data;
    logic          o_fifo_empty, o_fifo_full, o_fifo_almost_empty, o_fifo_almost_full;
    logic [DL:0]   o_fifo_items, o_fifo_peak;
    logic          o_fifo_overrun, o_fifo_underrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] sb_q[$];
    logic          m_ovr = 1'b0, m_udr = 1'b0;
    int            m_peak = 0;

    always #5 i_clk = ~i_clk;

    sd_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .AF_MARGIN  (AFM),
        .AE_MARGIN  (AEM)
    ) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_fifo_flush        (i_fifo_flush),
        .i_fifo_clear_errors (i_fifo_clear_errors),
        .i_fifo_push         (i_fifo_push),
        .i_fifo_data         (i_fifo_data),
        .i_fifo_pop          (i_fifo_pop),
        .o_fifo_data         (o_fifo_data),
        .o_fifo_empty        (o_fifo_empty),
        .o_fifo_full         (o_fifo_full),
        .o_fifo_almost_empty (o_fifo_almost_empty),
        .o_fifo_almost_full  (o_fifo_almost_full),
        .o_fifo_items        (o_fifo_items),
        .o_fifo_overrun      (o_fifo_overrun),
        .o_fifo_underrun     (o_fifo_underrun),
        .o_fifo_peak         (o_fifo_peak)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_peak();
`ifdef SD_FIFO_PEAK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    task automatic check_status();
        int n;
        n = sb_q.size();
        check("items", 32'(o_fifo_items), 32'(n));
        check("empty", 32'(o_fifo_empty), 32'(n == 0));
        check("full", 32'(o_fifo_full), 32'(n == DEPTH));
        check("almost_empty", 32'(o_fifo_almost_empty), 32'(n <= AEM));
        check("almost_full", 32'(o_fifo_almost_full), 32'(n >= DEPTH - AFM));
        check("overrun", 32'(o_fifo_overrun), 32'(m_ovr));
        check("underrun", 32'(o_fifo_underrun), 32'(m_udr));
        check("peak", 32'(o_fifo_peak), 32'(exp_peak()));
        if (n != 0) check("head", o_fifo_data, sb_q[0]);
    endtask

    task automatic cycle(input logic push, input logic [DW-1:0] data, input logic pop,
                         input logic flush, input logic clr);
        logic pa, wa;
        i_fifo_push = push;
        i_fifo_data = data;
        i_fifo_pop = pop;
        i_fifo_flush = flush;
        i_fifo_clear_errors = clr;
        if (flush) begin
            sb_q.delete();
            m_ovr = 1'b0;
            m_udr = 1'b0;
            m_peak = 0;
        end else begin
            pa = pop && (sb_q.size() > 0);
            wa = push && ((sb_q.size() < DEPTH) || pa);
            if (pa) check("pop_data", o_fifo_data, sb_q.pop_front());
            if (wa) sb_q.push_back(data);
            if (push && !wa) m_ovr = 1'b1;
            else if (clr)    m_ovr = 1'b0;
            if (pop && !pa)  m_udr = 1'b1;
            else if (clr)    m_udr = 1'b0;
            if (sb_q.size() > m_peak) m_peak = sb_q.size();
        end
        @(posedge i_clk);
        #1;
        i_fifo_push = 1'b0;
        i_fifo_pop = 1'b0;
        i_fifo_flush = 1'b0;
        i_fifo_clear_errors = 1'b0;
        check_status();
    endtask

    initial begin
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        check_status();

        // 1: fill to full, drain in order
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            if (i == 11) check("t1_af_below", 32'(o_fifo_almost_full), 32'd0);
            if (i == 12) check("t1_af_at12", 32'(o_fifo_almost_full), 32'd1);
        end
        check("t1_full", 32'(o_fifo_full), 32'd1);
        check("t1_items", 32'(o_fifo_items), 32'd16);
        for (int i = 1; i <= 16; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_empty", 32'(o_fifo_empty), 32'd1);

        // 2: overrun at full, then push+pop on full
        for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        check("t2_ovr", 32'(o_fifo_overrun), 32'd1);
        check("t2_head", o_fifo_data, 32'h1);
        cycle(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        check("t2_items", 32'(o_fifo_items), 32'd16);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_last", o_fifo_data, 32'hBEEF);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("t2_clr", 32'(o_fifo_overrun), 32'd0);

        // 3: underrun at empty, then push+pop on empty
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_udr", 32'(o_fifo_underrun), 32'd1);
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        check("t3_items", 32'(o_fifo_items), 32'd1);
        check("t3_head", o_fifo_data, 32'h55);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("t3_clr", 32'(o_fifo_underrun), 32'd0);

        // 4: steady-state pairs wrap the pointers
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 43; i++) begin
            cycle(1'b1, 32'h400 + DW'(i), 1'b1, 1'b0, 1'b0);
            check("t4_items3", 32'(o_fifo_items), 32'd3);
            check("t4_ae0", 32'(o_fifo_almost_empty), 32'd0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 5: flush beats push/pop and clears overrun
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h500 + DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h5FF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_items9", 32'(o_fifo_items), 32'd9);
        check("t5_ovr_sticky", 32'(o_fifo_overrun), 32'd1);
        cycle(1'b1, 32'h5AA, 1'b1, 1'b1, 1'b0);
        check("t5_items0", 32'(o_fifo_items), 32'd0);
        check("t5_ovr0", 32'(o_fifo_overrun), 32'd0);
        check("t5_peak0", 32'(o_fifo_peak), 32'd0);

        // 6: high-water mark
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'h600 + DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i < 9; i++) cycle(1'b1, 32'h600 + DW'(i), 1'b0, 1'b0, 1'b0);
        check("t6_items4", 32'(o_fifo_items), 32'd4);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef SD_FIFO_PEAK_EN
        check("t6_peak7", 32'(o_fifo_peak), 32'd7);
`else
        check("t6_peak_off", 32'(o_fifo_peak), 32'd0);
`endif

        // reset mid-transfer drops contents
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        sb_q.delete();
        m_ovr = 1'b0;
        m_udr = 1'b0;
        m_peak = 0;
        check_status();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
